// File: rtl/eink_panel_rx.sv
// ============================================================================
// Module   : eink_panel_rx
// Purpose  : Panel-side capture of ED060SC7 source/gate signals into
//            row-tagged framebuffer writes (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eink_panel_rx #(
    parameter int SOURCE_SIZE = 200,
    parameter int GATE_SIZE   = 600,
    parameter int ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cl,
    input  logic              sph,
    input  logic              le,
    input  logic              ckv,
    input  logic              spv,
    input  logic              oe,
    input  logic              gmode,
    input  logic [7:0]        data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic              frame_start,
    output logic [9:0]        row,
    output logic              row_valid,
    output logic              busy,
    output logic              err_col_ovf,
    output logic              err_drop,
    output logic              err_row_ovf,
    input  logic              err_clear
);

    localparam int COL_W = $clog2(SOURCE_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_STREAM = 2'd2
    } drain_state_t;

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
    logic       r_cl_s1, r_cl_s2, r_le_s1, r_le_s2, r_ckv_s1, r_ckv_s2;
    logic       r_sph_s1, r_spv_s1, r_gmode_s1, r_oe_s1;
    logic [7:0] r_data_s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cl_s1    <= 1'b0;
            r_cl_s2    <= 1'b0;
            r_le_s1    <= 1'b0;
            r_le_s2    <= 1'b0;
            r_ckv_s1   <= 1'b0;
            r_ckv_s2   <= 1'b0;
            r_sph_s1   <= 1'b1;
            r_spv_s1   <= 1'b1;
            r_gmode_s1 <= 1'b0;
            r_oe_s1    <= 1'b0;
            r_data_s1  <= 8'd0;
        end else begin
            r_cl_s1    <= cl;
            r_cl_s2    <= r_cl_s1;
            r_le_s1    <= le;
            r_le_s2    <= r_le_s1;
            r_ckv_s1   <= ckv;
            r_ckv_s2   <= r_ckv_s1;
            r_sph_s1   <= sph;
            r_spv_s1   <= spv;
            r_gmode_s1 <= gmode;
            r_oe_s1    <= oe;
            r_data_s1  <= data;
        end
    end

    // oe is observed for monitoring only and never gates capture
    logic w_oe_unused;
    assign w_oe_unused = r_oe_s1;

    logic w_cl_rise, w_le_rise, w_ckv_rise;
    assign w_cl_rise  = r_cl_s1  & ~r_cl_s2;
    assign w_le_rise  = r_le_s1  & ~r_le_s2;
    assign w_ckv_rise = r_ckv_s1 & ~r_ckv_s2;

    // ------------------------------------------------------------------
    // Line banks and column capture
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [2][SOURCE_SIZE];
    logic [1:0]       r_full;
    logic [COL_W-1:0] r_len [2];
    logic [9:0]       r_tag [2];
    logic             r_fill;
    logic             r_old;
    logic [COL_W-1:0] r_col;
    logic             r_lost;

    drain_state_t     r_state;
    logic             r_dbank;
    logic [COL_W-1:0] r_idx;
    logic             r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [7:0]       r_rd_data;

    logic             r_row_valid;
    logic [9:0]       r_row;
    logic             r_frame_start;
    logic             r_err_col, r_err_drop, r_err_row;

    logic             w_shift, w_col_room, w_capture, w_wr_en, w_lost;
    logic [COL_W-1:0] w_len;
    logic [COL_W-1:0] w_idx_next;
    logic             w_free, w_commit_line, w_commit_ok, w_drop, w_other_free;

    assign w_shift    = w_cl_rise & ~r_sph_s1;
    assign w_col_room = (r_col < COL_W'(SOURCE_SIZE));
    assign w_capture  = w_shift & w_col_room;
    assign w_wr_en    = w_capture & ~r_full[r_fill];
    // A byte that found no free bank taints the whole line so it is dropped, never half-written
    assign w_lost     = r_lost | (w_capture & r_full[r_fill]);
    assign w_len      = w_capture ? (r_col + COL_W'(1)) : r_col;

    assign w_idx_next    = r_idx + COL_W'(1);
    assign w_free        = (r_state == S_STREAM) & out_ready & (w_idx_next == r_len[r_dbank]);
    assign w_commit_line = w_le_rise & (w_len != '0) & r_row_valid;
    assign w_commit_ok   = w_commit_line & ~w_lost & ~r_full[r_fill];
    assign w_drop        = w_commit_line & (w_lost | r_full[r_fill]);
    assign w_other_free  = ~r_full[~r_fill] | (w_free & (r_dbank == ~r_fill));

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_fill][r_col] <= r_data_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= '0;
            r_lost <= 1'b0;
        end else if (w_le_rise) begin
            r_col  <= '0;
            r_lost <= 1'b0;
        end else if (w_capture) begin
            r_col  <= r_col + COL_W'(1);
            r_lost <= w_lost;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 2'b00;
            r_fill <= 1'b0;
            r_old  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                r_len[b] <= '0;
                r_tag[b] <= '0;
            end
        end else begin
            if (w_free) begin
                r_full[r_dbank] <= 1'b0;
            end
            if (w_commit_ok) begin
                r_full[r_fill] <= 1'b1;
                r_len[r_fill]  <= w_len;
                r_tag[r_fill]  <= r_row;
                if (w_other_free) begin
                    r_fill <= ~r_fill;
                    r_old  <= r_fill;
                end else begin
                    r_old  <= ~r_fill;
                end
            end else if (w_free && r_full[r_fill] && (r_dbank != r_fill)) begin
                // Fill was parked on a full bank; move it to the bank just freed
                r_fill <= r_dbank;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dbank     <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_rd_data   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_full != 2'b00) begin
                        r_dbank <= (r_full == 2'b11) ? r_old : ~r_full[0];
                        r_idx   <= '0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_rd_data   <= r_mem[r_dbank][r_idx];
                    r_out_addr  <= ADDR_W'(r_tag[r_dbank]) * ADDR_W'(SOURCE_SIZE)
                                   + ADDR_W'(r_idx);
                    r_out_valid <= 1'b1;
                    r_state     <= S_STREAM;
                end
                S_STREAM: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_idx       <= w_idx_next;
                        r_state     <= (w_idx_next == r_len[r_dbank]) ? S_IDLE : S_READ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Gate row tracking and sticky errors
    // ------------------------------------------------------------------
    logic w_gate_step, w_row_ovf;
    assign w_gate_step = w_ckv_rise & r_gmode_s1;
    assign w_row_ovf   = w_gate_step & r_spv_s1 & r_row_valid & (r_row == 10'(GATE_SIZE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row         <= 10'd0;
            r_row_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_gate_step) begin
                if (!r_spv_s1) begin
                    r_row         <= 10'd0;
                    r_row_valid   <= 1'b1;
                    r_frame_start <= 1'b1;
                end else if (r_row_valid && (r_row < 10'(GATE_SIZE - 1))) begin
                    r_row <= r_row + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_col  <= 1'b0;
            r_err_drop <= 1'b0;
            r_err_row  <= 1'b0;
        end else begin
            if (w_shift && !w_col_room) begin
                r_err_col <= 1'b1;
            end else if (err_clear) begin
                r_err_col <= 1'b0;
            end
            if (w_drop) begin
                r_err_drop <= 1'b1;
            end else if (err_clear) begin
                r_err_drop <= 1'b0;
            end
            if (w_row_ovf) begin
                r_err_row <= 1'b1;
            end else if (err_clear) begin
                r_err_row <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_addr    = r_out_addr;
    assign out_data    = r_rd_data;
    assign frame_start = r_frame_start;
    assign row         = r_row;
    assign row_valid   = r_row_valid;
    assign busy        = |r_full;
    assign err_col_ovf = r_err_col;
    assign err_drop    = r_err_drop;
    assign err_row_ovf = r_err_row;

endmodule

`default_nettype wire

// File: tb/tb_eink_panel_rx.sv
// ============================================================================
// Module   : tb_eink_panel_rx
// Purpose  : Scoreboard bench for eink_panel_rx framebuffer write stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eink_panel_rx;

    localparam int SS = 200;

    logic        clk = 1'b0;
    logic        rst, cl, sph, le, ckv, spv, oe, gmode, out_ready, err_clear;
    logic [7:0]  data;
    logic        out_valid, frame_start, row_valid, busy;
    logic        err_col_ovf, err_drop, err_row_ovf;
    logic [16:0] out_addr;
    logic [7:0]  out_data;
    logic [9:0]  row;

    eink_panel_rx #(.SOURCE_SIZE(SS), .GATE_SIZE(600), .ADDR_W(17)) u_dut (
        .clk(clk), .rst(rst), .cl(cl), .sph(sph), .le(le), .ckv(ckv), .spv(spv),
        .oe(oe), .gmode(gmode), .data(data), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .frame_start(frame_start), .row(row), .row_valid(row_valid), .busy(busy),
        .err_col_ovf(err_col_ovf), .err_drop(err_drop), .err_row_ovf(err_row_ovf),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          xfer_cnt = 0;
    int          fs_cnt   = 0;
    int          m_row    = 0;
    logic        p_stall  = 1'b0;
    logic [16:0] p_addr;
    logic [7:0]  p_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pop, hold-stability under backpressure, frame_start count
    always @(negedge clk) begin
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_addr", 32'(out_addr), 32'(p_addr));
                chk("hold_data", 32'(out_data), 32'(p_data));
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_out", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_addr", 32'(out_addr), 32'(e.a));
                    chk("out_data", 32'(out_data), 32'(e.d));
                end
            end
            p_stall = out_valid && !out_ready;
            p_addr  = out_addr;
            p_data  = out_data;
            if (frame_start) fs_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ckv_pulse(input logic spv_v);
        spv = spv_v;
        tick(2);
        ckv = 1'b1;
        tick(2);
        ckv = 1'b0;
        spv = 1'b1;
        tick(2);
    endtask

    // mode 0: data = index, mode 1: constant val, mode 2: index ^ val
    task automatic send_line(input int n, input int mode, input logic [7:0] val, input bit push);
        sph = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = (mode == 0) ? 8'(i) : (mode == 1) ? val : (8'(i) ^ val);
            data = d;
            cl = 1'b1;
            tick(2);
            cl = 1'b0;
            tick(2);
            if (push && i < SS) begin
                exp_t e;
                e.a = 17'(m_row * SS + i);
                e.d = d;
                exp_q.push_back(e);
            end
        end
        sph = 1'b1;
        tick(1);
    endtask

    task automatic le_pulse();
        le = 1'b1;
        tick(2);
        le = 1'b0;
        tick(2);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (exp_q.size() == 0 && !busy && !out_valid) begin
                done = 1'b1;
                break;
            end
            tick(1);
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        bit seen;
        rst = 1'b1; cl = 1'b0; sph = 1'b1; le = 1'b0; ckv = 1'b0; spv = 1'b1;
        oe = 1'b0; gmode = 1'b1; data = 8'd0; out_ready = 1'b1; err_clear = 1'b0;
        tick(4);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_row_valid", 32'(row_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_errs", 32'({err_col_ovf, err_drop, err_row_ovf}), 32'd0);
        rst = 1'b0;
        tick(3);

        // Line before any SPV is discarded
        oe = 1'b1;
        send_line(SS, 0, 8'd0, 1'b0);
        le_pulse();
        tick(10);
        chk("pre_spv_busy", 32'(busy), 32'd0);
        chk("pre_spv_xfer", 32'(xfer_cnt), 32'd0);

        // 1: frame start and full line
        ckv_pulse(1'b0);
        m_row = 0;
        chk("row_valid", 32'(row_valid), 32'd1);
        base = xfer_cnt;
        send_line(SS, 0, 8'd0, 1'b1);
        le_pulse();
        wait_drain();
        chk("fs_count1", 32'(fs_cnt), 32'd1);
        chk("line1_count", 32'(xfer_cnt - base), 32'd200);

        // 2: row advance
        repeat (3) ckv_pulse(1'b1);
        m_row = 3;
        chk("row3", 32'(row), 32'd3);
        base = xfer_cnt;
        send_line(SS, 1, 8'hAA, 1'b1);
        le_pulse();
        wait_drain();
        chk("line2_count", 32'(xfer_cnt - base), 32'd200);

        // 3: backpressure mid-drain
        base = xfer_cnt;
        send_line(SS, 2, 8'h5A, 1'b1);
        le_pulse();
        tick(20);
        out_ready = 1'b0;
        tick(50);
        out_ready = 1'b1;
        wait_drain();
        chk("bp_count", 32'(xfer_cnt - base), 32'd200);

        // 4: column overflow, then bank exhaustion
        base = xfer_cnt;
        send_line(205, 0, 8'd0, 1'b1);
        le_pulse();
        chk("col_ovf", 32'(err_col_ovf), 32'd1);
        wait_drain();
        chk("ovf_count", 32'(xfer_cnt - base), 32'd200);
        out_ready = 1'b0;
        base = xfer_cnt;
        for (int k = 0; k < 3; k++) begin
            ckv_pulse(1'b1);
            m_row = 4 + k;
            send_line(SS, 2, 8'(8'h30 + k), (k < 2));
            le_pulse();
        end
        chk("err_drop", 32'(err_drop), 32'd1);
        chk("busy_full", 32'(busy), 32'd1);
        out_ready = 1'b1;
        wait_drain();
        chk("drop_count", 32'(xfer_cnt - base), 32'd400);

        // 5: clear, row overflow, empty line
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("clear1", 32'({err_col_ovf, err_drop, err_row_ovf}), 32'd0);
        ckv_pulse(1'b0);
        chk("fs_count2", 32'(fs_cnt), 32'd2);
        repeat (600) ckv_pulse(1'b1);
        chk("row_ovf", 32'(err_row_ovf), 32'd1);
        chk("row599", 32'(row), 32'd599);
        base = xfer_cnt;
        le_pulse();
        tick(10);
        chk("empty_line_busy", 32'(busy), 32'd0);
        chk("empty_line_xfer", 32'(xfer_cnt - base), 32'd0);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("clear2", 32'({err_col_ovf, err_drop, err_row_ovf}), 32'd0);

        // 6: async reset while out_valid is high
        ckv_pulse(1'b0);
        m_row = 0;
        out_ready = 1'b0;
        send_line(SS, 2, 8'hFF, 1'b1);
        le_pulse();
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        chk("valid_before_rst", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_rowv", 32'(row_valid), 32'd0);
        exp_q.delete();
        tick(3);
        rst = 1'b0;
        out_ready = 1'b1;
        tick(3);
        ckv_pulse(1'b0);
        m_row = 0;
        base = xfer_cnt;
        send_line(SS, 2, 8'h3C, 1'b1);
        le_pulse();
        wait_drain();
        chk("post_rst_count", 32'(xfer_cnt - base), 32'd200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
